// File: rtl/freq_meter_mc.sv
// Multi-channel gated frequency meter: counts synchronised rising edges per channel over a
// gate of L reference cycles and latches all counts at once. `FREQ_METER_SAT_EN` selects saturating counters with overflow flags.
module freq_meter_mc #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned GATE_W      = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cont,
  input  logic [GATE_W-1:0]         gate_len,
  input  logic [CHANNELS-1:0]       test_in,
  output logic [CHANNELS*CNT_W-1:0] count_out,
  output logic                      valid,
  output logic                      busy,
  output logic [CHANNELS-1:0]       ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT,
    LATCH
  } state_t;

  state_t state, state_nxt;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] hist;
  logic [CHANNELS-1:0] edge_pulse;
  logic [GATE_W-1:0]   gate_cnt;
  logic                gate_last;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  // Synchroniser chain plus one history flop per channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      hist <= '0;
    end else begin
      sync_q[0] <= test_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~hist;
  assign gate_last  = (gate_cnt == GATE_W'(1));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     state_nxt = COUNT;
      COUNT:   if (gate_last) state_nxt = LATCH;
      LATCH:   state_nxt = cont ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A zero gate length is promoted to a single-cycle window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gate_cnt <= '0;
    end else if (state == ARM) begin
      gate_cnt <= (gate_len == '0) ? GATE_W'(1) : gate_len;
    end else if (state == COUNT) begin
      gate_cnt <= gate_cnt - GATE_W'(1);
    end
  end

`ifdef FREQ_METER_SAT_EN
  logic [CHANNELS-1:0] ovf_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
      end
      ovf_acc <= '0;
    end else if (state == ARM) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
      end
      ovf_acc <= '0;
    end else if (state == COUNT) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (edge_pulse[c]) begin
          if (cnt[c] == '1) begin
            ovf_acc[c] <= 1'b1;
          end else begin
            cnt[c] <= cnt[c] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= '0;
    end else if (state == LATCH) begin
      ovf <= ovf_acc;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
      end
    end else if (state == ARM) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
      end
    end else if (state == COUNT) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (edge_pulse[c]) begin
          cnt[c] <= cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  assign ovf = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_out <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= (state == LATCH);
      if (state == LATCH) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          count_out[c*CNT_W +: CNT_W] <= cnt[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_mc.sv
// Scoreboard bench for freq_meter_mc: a 32-bit instance for timing/counting scenarios and a
// 4-bit instance for wrap/saturation (expectation follows FREQ_METER_SAT_EN).
module tb_freq_meter_mc;

  typedef struct packed {
    logic [31:0]      cyc;
    logic [3:0][31:0] cnt;
    logic [3:0]       ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, start4, cont;
  logic         cont4 = 1'b0;
  logic [23:0]  gate_len;
  logic [3:0]   tin;
  logic [127:0] count_out;
  logic [15:0]  count_out4;
  logic         valid, valid4, busy, busy4;
  logic [3:0]   ovf, ovf4;

  int unsigned half [4];
  logic [3:0]  lvl;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t        sb[$];
  exp_t        sb4[$];

  freq_meter_mc #(.CHANNELS(4), .CNT_W(32), .GATE_W(24), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .gate_len(gate_len),
    .test_in(tin), .count_out(count_out), .valid(valid), .busy(busy), .ovf(ovf)
  );

  freq_meter_mc #(.CHANNELS(4), .CNT_W(4), .GATE_W(24), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .cont(cont4), .gate_len(gate_len),
    .test_in(tin), .count_out(count_out4), .valid(valid4), .busy(busy4), .ovf(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Test inputs change 2 ns after each negedge-aligned slot, never on a clock edge
  initial begin
    int unsigned ph [4];
    tin = '0;
    for (int c = 0; c < 4; c++) ph[c] = 0;
    #2;
    forever begin
      for (int c = 0; c < 4; c++) begin
        if (half[c] == 0) begin
          tin[c] = lvl[c];
          ph[c]  = 0;
        end else if (ph[c] + 1 >= half[c]) begin
          ph[c]  = 0;
          tin[c] = ~tin[c];
        end else begin
          ph[c]++;
        end
      end
      #10;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("valid_unexpected", 32'(valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_cyc", cyc, e.cyc);
        for (int i = 0; i < 4; i++) check($sformatf("cnt%0d", i), count_out[i*32 +: 32], e.cnt[i]);
        check("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
    if (rst === 1'b1 && valid4 === 1'b1) begin
      if (sb4.size() == 0) begin
        check("valid4_unexpected", 32'(valid4), 32'd0);
      end else begin
        exp_t e;
        e = sb4.pop_front();
        check("valid4_cyc", cyc, e.cyc);
        for (int i = 0; i < 4; i++) check($sformatf("cnt4_%0d", i), 32'(count_out4[i*4 +: 4]), e.cnt[i]);
        check("ovf4", 32'(ovf4), 32'(e.ovf));
      end
    end
  end

  task automatic push_exp(input bit to4, input int unsigned at, input logic [31:0] c0,
                          input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3,
                          input logic [3:0] ov);
    exp_t e;
    e.cyc = at;
    e.cnt[0] = c0; e.cnt[1] = c1; e.cnt[2] = c2; e.cnt[3] = c3;
    e.ovf = ov;
    if (to4) sb4.push_back(e);
    else sb.push_back(e);
  endtask

  task automatic pulse_start(output int unsigned e0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    e0 = cyc;
  endtask

  task automatic pulse_start4(output int unsigned e0);
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_cyc(input int unsigned target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int i = 0; i < 4; i++) check($sformatf("%s_cnt%0d", tag, i), count_out[i*32 +: 32], 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_ovf"},   32'(ovf),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    logic [31:0] sat_cnt;
    logic [3:0]  sat_ovf;
`ifdef FREQ_METER_SAT_EN
    sat_cnt = 32'd15; sat_ovf = 4'b0001;
`else
    sat_cnt = 32'd9;  sat_ovf = 4'b0000;
`endif
    rst = 1'b0; start = 1'b0; start4 = 1'b0; cont = 1'b0; gate_len = '0; lvl = '0;
    for (int c = 0; c < 4; c++) half[c] = 0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;

    // L=1000, ch0 period 10
    half[0] = 5;
    repeat (20) @(negedge clk);
    gate_len = 24'd1000;
    pulse_start(e0);
    check("busy_rise", 32'(busy), 32'd1);
    push_exp(1'b0, e0 + 1002, 32'd100, 32'd0, 32'd0, 32'd0, 4'b0);
    wait_cyc(e0 + 1001);
    check("busy_in_latch", 32'(busy), 32'd1);
    wait_cyc(e0 + 1002);
    check("busy_fall", 32'(busy), 32'd0);

    // L=0 behaves as L=1; ch2 edge long before start is not counted
    half[0] = 0; lvl[2] = 1'b1;
    repeat (20) @(negedge clk);
    gate_len = 24'd0;
    pulse_start(e0);
    push_exp(1'b0, e0 + 3, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0);
    wait_cyc(e0 + 10);

    // Continuous mode, L=200, ch1 period 4; cont dropped mid third window
    lvl[2] = 1'b0; half[1] = 2;
    repeat (20) @(negedge clk);
    gate_len = 24'd200; cont = 1'b1;
    pulse_start(e0);
    for (int k = 1; k <= 3; k++) push_exp(1'b0, e0 + 202*k, 32'd0, 32'd50, 32'd0, 32'd0, 4'b0);
    wait_cyc(e0 + 504);
    cont = 1'b0;
    wait_cyc(e0 + 605);
    check("cont_busy_last_latch", 32'(busy), 32'd1);
    wait_cyc(e0 + 610);
    check("cont_busy_end", 32'(busy), 32'd0);
    check("cont_sb_left", 32'(sb.size()), 32'd0);

    // 4-bit counters, 25 edges in L=100
    half[1] = 0; half[0] = 2;
    repeat (20) @(negedge clk);
    gate_len = 24'd100;
    pulse_start4(e0);
    push_exp(1'b1, e0 + 102, sat_cnt, 32'd0, 32'd0, 32'd0, sat_ovf);
    wait_cyc(e0 + 110);

    // Reset during COUNT, then a clean L=50 run with no edges
    half[0] = 5;
    repeat (20) @(negedge clk);
    gate_len = 24'd1000;
    pulse_start(e0);
    wait_cyc(e0 + 300);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    half[0] = 0;
    repeat (10) @(negedge clk);
    gate_len = 24'd50;
    pulse_start(e0);
    push_exp(1'b0, e0 + 52, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0);
    wait_cyc(e0 + 60);

    // Second start during COUNT is ignored
    half[0] = 5;
    repeat (30) @(negedge clk);
    gate_len = 24'd100;
    pulse_start(e0);
    push_exp(1'b0, e0 + 102, 32'd10, 32'd0, 32'd0, 32'd0, 4'b0);
    wait_cyc(e0 + 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(e0 + 150);
    check("restart_busy", 32'(busy), 32'd0);

    check("sb_left", 32'(sb.size()), 32'd0);
    check("sb4_left", 32'(sb4.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/freq_meter_mc.md
# freq_meter_mc

Multi-channel gated frequency meter: counts rising edges of up to CHANNELS asynchronous test inputs during a programmable gate window measured in reference-clock cycles, then latches all channel counts simultaneously and pulses a valid strobe. It is the parametrised successor to the single-channel frequency detector in the synchronisation block. Channel count, counter width and gate length are configurable. It adds input synchronisation, single-shot and continuous modes, and per-channel overflow reporting.

## Interface
- CHANNELS, 4, number of test inputs (1..32)
- CNT_W, 32, edge-counter and result width per channel
- GATE_W, 24, width of gate-length input
- SYNC_STAGES, 2, synchroniser flops per test input (>=2)
- clk  in  1  reference clock; all logic in this domain
- rst  in  1  reset, asynchronous, active-low; clock clk
- start  in  1  begin a measurement; sampled only in IDLE
- cont  in  1  continuous mode; sampled in LATCH
- gate_len  in  GATE_W  gate length L in clk cycles; sampled in ARM; 0 treated as 1
- test_in  in  CHANNELS  asynchronous signals under measurement
- count_out  out  CHANNELS*CNT_W  latched counts; channel i at [i*CNT_W +: CNT_W]
- valid  out  1  one-cycle pulse when count_out updates
- busy  out  1  high in every state except IDLE
- ovf  out  CHANNELS  per-channel overflow of the last latched window

## Operation
- Per channel: SYNC_STAGES flops, then one history flop. A rising edge is sync & ~hist.
- All synchroniser and history flops reset to 0.
- FSM states: IDLE, ARM, COUNT, LATCH. Encoding is free.
  - IDLE: start=1 -> ARM. start while busy is ignored, not queued.
  - ARM: clear all edge counters and overflow flags; load gate_cnt = max(gate_len, 1) -> COUNT.
  - COUNT: on each cycle, every channel with an edge pulse increments its counter. gate_cnt decrements; when gate_cnt==1 -> LATCH.
  - LATCH: copy all counters to count_out and flags to ovf; pulse valid. cont=1 -> ARM, else -> IDLE.
- Edge pulses occurring outside COUNT are discarded.
- Counters run modulo or saturate per Configuration. The width rule is CNT_W bits, unsigned.
- count_out and ovf hold their value until the next LATCH.
- cont dropped mid-window: the current window completes and latches, then the FSM goes to IDLE.
- Reset mid-operation: FSM to IDLE, counters cleared, and outputs return to reset values immediately.

## Timing
- Reset values:
  - count_out = 0, valid = 0, busy = 0, ovf = 0.
  - FSM = IDLE, gate_cnt = 0.
- Latency: let edge E0 sample start=1 in IDLE.
  - ARM occupies the cycle after E0.
  - COUNT occupies exactly L cycles.
  - LATCH follows.
  - valid is high in the cycle after edge E0+L+2, for exactly one cycle.
- Continuous mode dead time: 2 cycles (LATCH and ARM) per window; edges in those cycles are not counted. Window period is L+2 cycles.
- Input-to-count latency: SYNC_STAGES+1 cycles. Edges within that distance of the gate boundary land in the window where their pulse appears.
- Inputs are valid for f_test < f_clk/2 with high and low phases each >= 1 clk period. Faster inputs are undercounted.
- busy rises the cycle after E0. busy falls the cycle after LATCH when cont=0.

## Configuration
- FREQ_METER_SAT_EN defined:
  - Each counter saturates at 2^CNT_W-1.
  - The channel's ovf flag sets on the first increment attempted at saturation and is latched in LATCH.
- FREQ_METER_SAT_EN undefined:
  - Counters wrap modulo 2^CNT_W.
  - ovf is constant 0 and the saturation logic is removed.

## Test plan
- CHANNELS=4, L=1000, test_in[0] period 10 clk, other inputs static, start pulse -> one valid pulse 1002 cycles after the start edge; ch0 = 100 (+/-1); ch1..3 = 0; busy drops after LATCH.
- L=0, single toggle on ch2 held long before start -> counts 0. L=0 also behaves as L=1: valid 3 cycles after start.
- cont=1, L=200, ch1 period 4 clk -> valid every 202 cycles; each ch1 result 50 (+/-1). Clear cont mid-window -> exactly one more valid, then busy=0.
- CNT_W=4, L=100, ch0 period 4 clk (25 edges):
  - With FREQ_METER_SAT_EN: ch0 = 15, ovf[0] = 1.
  - Without FREQ_METER_SAT_EN: ch0 = 25 mod 16 = 9, ovf = 0.
- Assert rst low during COUNT, release, then start with L=50 and no edges -> all outputs 0 during reset; next valid gives all counts 0 and ovf = 0.
- start pulsed again during COUNT -> ignored; exactly one valid; result unchanged vs. the single-start run.
